key_scan_ctrl: RTL and testbench



---
 rtl/calc_pkg.sv | 52 +++++
 rtl/sync2.sv | 28 ++
 rtl/key_scan_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner states and the 4x4 key map.
package calc_pkg;

    localparam logic [3:0] KEY_0   = 4'h0;
    localparam logic [3:0] KEY_1   = 4'h1;
    localparam logic [3:0] KEY_2   = 4'h2;
    localparam logic [3:0] KEY_3   = 4'h3;
    localparam logic [3:0] KEY_4   = 4'h4;
    localparam logic [3:0] KEY_5   = 4'h5;
    localparam logic [3:0] KEY_6   = 4'h6;
    localparam logic [3:0] KEY_7   = 4'h7;
    localparam logic [3:0] KEY_8   = 4'h8;
    localparam logic [3:0] KEY_9   = 4'h9;
    localparam logic [3:0] KEY_ADD = 4'ha;
    localparam logic [3:0] KEY_SUB = 4'hb;
    localparam logic [3:0] KEY_MUL = 4'hc;
    localparam logic [3:0] KEY_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    // Physical position (row, column) to key code.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = KEY_1;
            4'h1:    code = KEY_2;
            4'h2:    code = KEY_3;
            4'h3:    code = KEY_ADD;
            4'h4:    code = KEY_4;
            4'h5:    code = KEY_5;
            4'h6:    code = KEY_6;
            4'h7:    code = KEY_SUB;
            4'h8:    code = KEY_7;
            4'h9:    code = KEY_8;
            4'ha:    code = KEY_9;
            4'hb:    code = KEY_MUL;
            4'hc:    code = KEY_CLR;
            4'hd:    code = KEY_0;
            4'he:    code = KEY_EQ;
            default: code = KEY_DIV;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync2 #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage1_reg;
    logic [WIDTH-1:0] stage2_reg;

    // Two back-to-back registers give metastability time to resolve.
    always_ff @(posedge clk) begin
        if (srst) begin
            stage1_reg <= RESET_VAL;
            stage2_reg <= RESET_VAL;
        end else begin
            stage1_reg <= din;
            stage2_reg <= stage1_reg;
        end
    end

    assign dout = stage2_reg;

endmodule

// File: rtl/key_scan_ctrl.sv
// 4x4 keypad scanner: column rotation, full-scan classification, debounce and
// release detection, producing one flag pulse per accepted press.
module key_scan_ctrl
    import calc_pkg::*;
#(
    parameter int COL_HOLD  = 4,
    parameter int DEB_SCANS = 3,
    parameter int REL_SCANS = 2
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] key_value,
    output logic       flag,
    output logic       key_held
);

    localparam int HOLD_W = $clog2(COL_HOLD);
    localparam int DEB_W  = $clog2(DEB_SCANS + 1);
    localparam int REL_W  = $clog2(REL_SCANS + 1);

    logic [3:0]        row_sync;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [1:0]        col_idx_reg;
    logic              sample_en;
    logic              scan_end;
    logic [15:0]       scan_vec;     // bit col*4+row set when that key was seen pressed
    logic [4:0]        hits;
    logic [3:0]        hit_idx;
    logic              scan_is_none;
    logic              scan_is_key;
    logic [3:0]        scan_code;

    scan_state_t       state_reg, state_next;
    logic [3:0]        cand_reg, cand_next;
    logic [DEB_W-1:0]  cnt_reg, cnt_next;
    logic [REL_W-1:0]  rcnt_reg, rcnt_next;
    logic [3:0]        key_value_reg, key_value_next;
    logic              flag_reg, flag_next;
    logic              held_reg, held_next;

    sync2 #(.WIDTH(4), .RESET_VAL(4'hf)) u_row_sync (
        .clk  (CLK_1K),
        .srst (RST),
        .din  (ROW),
        .dout (row_sync)
    );

    assign sample_en = (hold_cnt_reg == HOLD_W'(COL_HOLD - 1));
    assign scan_end  = sample_en && (col_idx_reg == 2'd3);
    assign COL       = ~(4'b0001 << col_idx_reg);

    // Column hold timer and column rotation.
    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            hold_cnt_reg <= '0;
            col_idx_reg  <= '0;
        end else if (sample_en) begin
            hold_cnt_reg <= '0;
            col_idx_reg  <= col_idx_reg + 2'd1;
        end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
    end

    // Per-column capture; the column being sampled now is taken live so the
    // full scan is complete in the same cycle as its last sample.
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [3:0] press_reg;

        // Latch active-high press bits of this column at the end of its hold.
        always_ff @(posedge CLK_1K) begin
            if (RST) begin
                press_reg <= '0;
            end else if (sample_en && (col_idx_reg == 2'(gi))) begin
                press_reg <= ~row_sync;
            end
        end

        assign scan_vec[gi*4 +: 4] = (col_idx_reg == 2'(gi)) ? ~row_sync : press_reg;
    end

    // Count pressed positions and remember the (only meaningful if single) index.
    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (scan_vec[i]) begin
                hits    = hits + 5'd1;
                hit_idx = 4'(i);
            end
        end
    end

    assign scan_is_none = (hits == 5'd0);
    assign scan_is_key  = (hits == 5'd1);
    assign scan_code    = key_map(hit_idx[1:0], hit_idx[3:2]);

    // State and output registers.
    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            state_reg     <= IDLE;
            cand_reg      <= '0;
            cnt_reg       <= '0;
            rcnt_reg      <= '0;
            key_value_reg <= '0;
            flag_reg      <= 1'b0;
            held_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cand_reg      <= cand_next;
            cnt_reg       <= cnt_next;
            rcnt_reg      <= rcnt_next;
            key_value_reg <= key_value_next;
            flag_reg      <= flag_next;
            held_reg      <= held_next;
        end
    end

    // Debounce/release decisions, taken once per completed full scan.
    always_comb begin
        state_next     = state_reg;
        cand_next      = cand_reg;
        cnt_next       = cnt_reg;
        rcnt_next      = rcnt_reg;
        key_value_next = key_value_reg;
        held_next      = held_reg;
        flag_next      = 1'b0;
        if (scan_end) begin
            case (state_reg)
                IDLE: begin
                    if (scan_is_key) begin
                        state_next = DEBOUNCE;
                        cand_next  = scan_code;
                        cnt_next   = DEB_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!scan_is_key) begin
                        state_next = IDLE;
                    end else if (scan_code != cand_reg) begin
                        cand_next = scan_code;
                        cnt_next  = DEB_W'(1);
                    end else if (cnt_reg + DEB_W'(1) == DEB_W'(DEB_SCANS)) begin
                        key_value_next = cand_reg;
                        flag_next      = 1'b1;
                        held_next      = 1'b1;
                        cnt_next       = '0;
                        state_next     = PRESSED;
                    end else begin
                        cnt_next = cnt_reg + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    // Other keys or chords while held are ignored: no rollover.
                    if (scan_is_none) begin
                        state_next = RELEASE;
                        rcnt_next  = REL_W'(1);
                    end
                end
                RELEASE: begin
                    if (!scan_is_none) begin
                        state_next = PRESSED;
                    end else if (rcnt_reg + REL_W'(1) == REL_W'(REL_SCANS)) begin
                        held_next  = 1'b0;
                        rcnt_next  = '0;
                        state_next = IDLE;
                    end else begin
                        rcnt_next = rcnt_reg + REL_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign key_value = key_value_reg;
    assign flag      = flag_reg;
    assign key_held  = held_reg;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Self-checking bench for key_scan_ctrl: a keypad model drives ROW from COL and
// a scan-level reference model predicts flag, key_value and key_held.
module tb_key_scan_ctrl;

    localparam int COL_HOLD  = 4;
    localparam int DEB_SCANS = 3;
    localparam int REL_SCANS = 2;
    localparam int SCAN_LEN  = 4 * COL_HOLD;

    // Key code by keypad position, indexed row*4+col (same as the press mask bits).
    localparam logic [3:0] KEYTAB [16] = '{
        4'h1, 4'h2, 4'h3, 4'ha,
        4'h4, 4'h5, 4'h6, 4'hb,
        4'h7, 4'h8, 4'h9, 4'hc,
        4'hf, 4'h0, 4'he, 4'hd
    };

    logic       CLK_1K = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ROW = 4'hf;
    logic [3:0] COL;
    logic [3:0] key_value;
    logic       flag;
    logic       key_held;

    key_scan_ctrl #(.COL_HOLD(COL_HOLD), .DEB_SCANS(DEB_SCANS), .REL_SCANS(REL_SCANS)) dut (
        .CLK_1K    (CLK_1K),
        .RST       (RST),
        .ROW       (ROW),
        .COL       (COL),
        .key_value (key_value),
        .flag      (flag),
        .key_held  (key_held)
    );

    always #5 CLK_1K = ~CLK_1K;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          col_bad = 0;
    int          dbl_flags = 0;
    int          scan_flags = 0;
    int          last_flag_cyc = 0;
    logic [3:0]  last_flag_code = '0;
    logic        prev_flag = 1'b0;
    logic [15:0] pressed = '0;

    // Reference model state (scan level).
    int          m_streak = 0;
    int          m_rel = 0;
    logic        m_held = 1'b0;
    logic [3:0]  m_cand = '0;
    logic [3:0]  m_code = '0;
    int          exp_flags = 0;

    task automatic drive_row();
        logic [3:0] r;
        r = 4'hf;
        for (int c = 0; c < 4; c++)
            if (COL[c] == 1'b0)
                for (int rr = 0; rr < 4; rr++)
                    if (pressed[rr*4+c]) r[rr] = 1'b0;
        ROW = r;
    endtask

    task automatic tick();
        logic [3:0] exp_col;
        @(posedge CLK_1K);
        #1;
        cyc++;
        drive_row();
        exp_col = ~(4'b0001 << ((cyc / COL_HOLD) % 4));
        if (COL !== exp_col) col_bad++;
        if (flag === 1'b1) begin
            scan_flags++;
            last_flag_cyc  = cyc;
            last_flag_code = key_value;
            if (prev_flag) dbl_flags++;
        end
        prev_flag = (flag === 1'b1);
    endtask

    task automatic model_step(input logic [15:0] mask);
        int n;
        int idx;
        n = $countones(mask);
        idx = 0;
        for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
        exp_flags = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak > 0 && KEYTAB[idx] == m_cand) m_streak++;
                else begin
                    m_cand = KEYTAB[idx];
                    m_streak = 1;
                end
                if (m_streak == DEB_SCANS) begin
                    exp_flags = 1;
                    m_code = m_cand;
                    m_held = 1'b1;
                    m_streak = 0;
                    m_rel = 0;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (n == 0) begin
                m_rel++;
                if (m_rel == REL_SCANS) begin
                    m_held = 1'b0;
                    m_rel = 0;
                end
            end else begin
                m_rel = 0;
            end
        end
    endtask

    // One full scan with a fixed set of pressed keys, aligned to the scan start.
    task automatic scan(input logic [15:0] mask);
        pressed = mask;
        drive_row();
        scan_flags = 0;
        repeat (SCAN_LEN) tick();
        model_step(mask);
    endtask

    // Reset for the given number of cycles; pressed keys stay as they are.
    task automatic do_reset(input int cycles);
        RST = 1'b1;
        repeat (cycles) @(posedge CLK_1K);
        #1;
        RST = 1'b0;
        cyc = 0;
        prev_flag = 1'b0;
        drive_row();
        m_streak = 0;
        m_rel = 0;
        m_held = 1'b0;
        m_cand = '0;
        m_code = '0;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_cmp++; if (COL !== 4'b1110) begin n_bad++; $display("FAIL reset_col: got %b want 1110", COL); end
        n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL reset_flag: got %b want 0", flag); end
        n_cmp++; if (key_value !== 4'h0) begin n_bad++; $display("FAIL reset_key_value: got %h want 0", key_value); end
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL reset_key_held: got %b want 0", key_held); end
        $display("reset: COL=%b flag=%b key_value=%h key_held=%b", COL, flag, key_value, key_held);
    endtask

    task automatic test_idle();
        int flags_total;
        flags_total = 0;
        col_bad = 0;
        for (int s = 0; s < 7; s++) begin
            scan(16'h0000);
            flags_total += scan_flags;
        end
        n_cmp++; if (flags_total !== 0) begin n_bad++; $display("FAIL idle_flags: got %0d want 0", flags_total); end
        n_cmp++; if (col_bad !== 0) begin n_bad++; $display("FAIL idle_col_rotation: %0d bad cycles want 0", col_bad); end
        n_cmp++; if (key_value !== 4'h0) begin n_bad++; $display("FAIL idle_key_value: got %h want 0", key_value); end
        $display("idle: 112 cycles, flags=%0d col_errors=%0d", flags_total, col_bad);
    endtask

    task automatic test_single_press();
        int press_cyc;
        press_cyc = cyc;
        for (int s = 0; s < 16; s++) begin
            scan(s < 13 ? 16'h0004 : 16'h0000);
            n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL press3_flag scan %0d: got %0d want %0d", s, scan_flags, exp_flags); end
            n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL press3_key_value scan %0d: got %h want %h", s, key_value, m_code); end
            n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL press3_key_held scan %0d: got %b want %b", s, key_held, m_held); end
        end
        n_cmp++; if (last_flag_cyc - press_cyc !== DEB_SCANS * SCAN_LEN) begin
            n_bad++; $display("FAIL press3_latency: got %0d want %0d", last_flag_cyc - press_cyc, DEB_SCANS * SCAN_LEN);
        end
        $display("single press key 3: flag latency %0d cycles, code %h", last_flag_cyc - press_cyc, last_flag_code);
    endtask

    task automatic test_bounce();
        logic [15:0] seq [12] = '{16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000,
                                  16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'h0000, 16'h0000};
        for (int s = 0; s < 12; s++) begin
            scan(seq[s]);
            n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL bounce_flag scan %0d: got %0d want %0d", s, scan_flags, exp_flags); end
            n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL bounce_key_value scan %0d: got %h want %h", s, key_value, m_code); end
            n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL bounce_key_held scan %0d: got %b want %b", s, key_held, m_held); end
        end
        $display("bounce key f: last code %h", key_value);
    endtask

    task automatic test_multi_key();
        logic [15:0] seq [10] = '{16'h0021, 16'h0021, 16'h0021, 16'h0021,
                                  16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000};
        for (int s = 0; s < 10; s++) begin
            scan(seq[s]);
            n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL multi_flag scan %0d: got %0d want %0d", s, scan_flags, exp_flags); end
            n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL multi_key_value scan %0d: got %h want %h", s, key_value, m_code); end
            n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL multi_key_held scan %0d: got %b want %b", s, key_held, m_held); end
        end
        $display("multi key 1+5 then 1: last code %h", key_value);
    endtask

    task automatic test_rollover();
        logic [15:0] seq [11] = '{16'h0100, 16'h0100, 16'h0100, 16'h0500, 16'h0500,
                                  16'h0400, 16'h0400, 16'h0400, 16'h0000, 16'h0000, 16'h0000};
        for (int s = 0; s < 11; s++) begin
            scan(seq[s]);
            n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL rollover_flag scan %0d: got %0d want %0d", s, scan_flags, exp_flags); end
            n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL rollover_key_value scan %0d: got %h want %h", s, key_value, m_code); end
            n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL rollover_key_held scan %0d: got %b want %b", s, key_held, m_held); end
        end
        $display("rollover 7 -> 7+9 -> 9: last code %h held %b", key_value, key_held);
    endtask

    task automatic test_reset_mid_debounce();
        // Key 4 accepted and held, then reset mid-press.
        for (int s = 0; s < 4; s++) scan(16'h0010);
        do_reset(1);
        n_cmp++; if (key_held !== 1'b0) begin n_bad++; $display("FAIL rst_press_key_held: got %b want 0", key_held); end
        n_cmp++; if (key_value !== 4'h0) begin n_bad++; $display("FAIL rst_press_key_value: got %h want 0", key_value); end
        // Release, then key 4 reaches a count of two and reset hits.
        for (int s = 0; s < 3; s++) scan(16'h0000);
        scan(16'h0010);
        scan(16'h0010);
        do_reset(1);
        n_cmp++; if (COL !== 4'b1110) begin n_bad++; $display("FAIL rst_deb_col: got %b want 1110", COL); end
        n_cmp++; if (flag !== 1'b0) begin n_bad++; $display("FAIL rst_deb_flag: got %b want 0", flag); end
        for (int s = 0; s < 5; s++) begin
            scan(s < 3 ? 16'h0010 : 16'h0000);
            n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL rst_deb_flag scan %0d: got %0d want %0d", s, scan_flags, exp_flags); end
            n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL rst_deb_key_value scan %0d: got %h want %h", s, key_value, m_code); end
            n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL rst_deb_key_held scan %0d: got %b want %b", s, key_held, m_held); end
        end
        $display("reset mid-debounce: key 4 flag at cycle %0d after reset", last_flag_cyc);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int sel;
        int reps;
        int k1;
        int k2;
        col_bad = 0;
        dbl_flags = 0;
        for (int seg = 0; seg < 50; seg++) begin
            sel = $urandom_range(0, 9);
            k1 = $urandom_range(0, 15);
            k2 = (k1 + $urandom_range(1, 15)) % 16;
            mask = '0;
            if (sel >= 4) mask[k1] = 1'b1;
            if (sel >= 8) mask[k2] = 1'b1;
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                scan(mask);
                n_cmp++; if (scan_flags !== exp_flags) begin n_bad++; $display("FAIL rand_flag seg %0d: got %0d want %0d", seg, scan_flags, exp_flags); end
                n_cmp++; if (key_value !== m_code) begin n_bad++; $display("FAIL rand_key_value seg %0d: got %h want %h", seg, key_value, m_code); end
                n_cmp++; if (key_held !== m_held) begin n_bad++; $display("FAIL rand_key_held seg %0d: got %b want %b", seg, key_held, m_held); end
            end
            $display("random seg %0d: mask=%h scans=%0d key_value=%h key_held=%b", seg, mask, reps, key_value, key_held);
        end
        n_cmp++; if (dbl_flags !== 0) begin n_bad++; $display("FAIL back_to_back_flag: got %0d want 0", dbl_flags); end
        n_cmp++; if (col_bad !== 0) begin n_bad++; $display("FAIL rand_col_rotation: %0d bad cycles want 0", col_bad); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_rollover();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
